// File: rtl/dtree_seq_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : dtree_seq_engine_if
// Description : Feature-in, class-out and node-table config bundle of the
//               decision-tree engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface dtree_seq_engine_if #(
    parameter int N_FEAT    = 18,
    parameter int FEAT_W    = 8,
    parameter int N_NODES   = 64,
    parameter int CLASS_W   = 2,
    parameter int MAX_DEPTH = 12
);
    localparam int FI_W   = $clog2(N_FEAT);
    localparam int K_W    = $clog2(FEAT_W + 1);
    localparam int NI_W   = $clog2(N_NODES);
    localparam int NODE_W = 1 + FI_W + K_W + FEAT_W + 2 * NI_W;
    localparam int DEP_W  = $clog2(MAX_DEPTH + 2);

    logic                       in_valid;
    logic                       in_ready;
    logic [N_FEAT*FEAT_W-1:0]   in_feat;
    logic                       out_valid;
    logic                       out_ready;
    logic [CLASS_W-1:0]         out_class;
    logic [DEP_W-1:0]           out_depth;
    logic                       out_err;
    logic                       cfg_we;
    logic [NI_W-1:0]            cfg_addr;
    logic [NODE_W-1:0]          cfg_wdata;
    logic                       cfg_ready;

    modport master (
        output in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, out_class, out_depth, out_err, cfg_ready
    );

    modport slave (
        input  in_valid, in_feat, out_ready, cfg_we, cfg_addr, cfg_wdata,
        output in_ready, out_valid, out_class, out_depth, out_err, cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/dtree_seq_engine.sv
`default_nettype none
// ============================================================================
// Module      : dtree_seq_engine
// Description : Node-serial decision-tree classifier walking a programmable
//               node table one node per clock. Optional macro
//               DTREE_CLASS_STATS_EN adds per-class result counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dtree_seq_engine #(
    parameter int N_FEAT    = 18,
    parameter int FEAT_W    = 8,
    parameter int N_NODES   = 64,
    parameter int CLASS_W   = 2,
    parameter int MAX_DEPTH = 12
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
`ifdef DTREE_CLASS_STATS_EN
    input  wire logic                      stat_clr,
    output logic [(2**CLASS_W)*16-1:0]     stat_cnt,
`endif
    dtree_seq_engine_if.slave              bus
);
    localparam int FI_W    = $clog2(N_FEAT);
    localparam int K_W     = $clog2(FEAT_W + 1);
    localparam int NI_W    = $clog2(N_NODES);
    localparam int NODE_W  = 1 + FI_W + K_W + FEAT_W + 2 * NI_W;
    localparam int DEP_W   = $clog2(MAX_DEPTH + 2);
    localparam int N_FSLOT = 2 ** FI_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [NODE_W-1:0]         r_table [N_NODES];
    logic [NODE_W-1:0]         r_node;
    logic [N_FEAT*FEAT_W-1:0]  r_feat;
    logic                      r_fetched;
    logic                      r_bad;
    logic [DEP_W-1:0]          r_depth;
    logic [CLASS_W-1:0]        r_out_class;
    logic [DEP_W-1:0]          r_out_depth;
    logic                      r_out_err;

    logic                      w_in_ready;
    logic                      w_cfg_ready;
    logic                      w_out_valid;
    logic                      w_finish;
    logic [CLASS_W-1:0]        w_res_class;
    logic                      w_res_err;
    logic [DEP_W-1:0]          w_res_depth;

    // Fields of the node currently held in r_node
    logic                      w_leaf;
    logic [FI_W-1:0]           w_fidx;
    logic [K_W-1:0]            w_keep;
    logic [FEAT_W-1:0]         w_thresh;
    logic [NI_W-1:0]           w_left;
    logic [NI_W-1:0]           w_right;

    assign w_leaf   = r_node[NODE_W-1];
    assign w_fidx   = r_node[2*NI_W+FEAT_W+K_W +: FI_W];
    assign w_keep   = r_node[2*NI_W+FEAT_W +: K_W];
    assign w_thresh = r_node[2*NI_W +: FEAT_W];
    assign w_left   = r_node[NI_W +: NI_W];
    assign w_right  = r_node[0 +: NI_W];

    // Feature indices beyond N_FEAT read as zero
    logic [FEAT_W-1:0]         w_feat_slot [N_FSLOT];
    for (genvar gi = 0; gi < N_FSLOT; gi++) begin : g_feat
        if (gi < N_FEAT) begin : g_real
            assign w_feat_slot[gi] = r_feat[gi*FEAT_W +: FEAT_W];
        end else begin : g_pad
            assign w_feat_slot[gi] = '0;
        end
    end

    logic [FEAT_W-1:0]         w_feat_sel;
    logic [K_W-1:0]            w_keep_eff;
    logic [K_W-1:0]            w_shift;
    logic [FEAT_W-1:0]         w_slice;
    logic [NI_W-1:0]           w_child;
    logic                      w_child_bad;
    logic [DEP_W-1:0]          w_depth_inc;

    always_comb begin
        w_keep_eff = w_keep;
        if (w_keep == '0 || int'(w_keep) > FEAT_W) begin
            w_keep_eff = K_W'(FEAT_W);
        end
    end

    assign w_feat_sel  = w_feat_slot[w_fidx];
    assign w_shift     = K_W'(FEAT_W) - w_keep_eff;
    assign w_slice     = w_feat_sel >> w_shift;
    assign w_child     = (w_slice <= w_thresh) ? w_left : w_right;
    assign w_child_bad = int'(w_child) >= N_NODES;
    assign w_depth_inc = r_depth + DEP_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // First WALK cycle only fetches the root; every later cycle evaluates r_node
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_cfg_ready = 1'b0;
        w_out_valid = 1'b0;
        w_finish    = 1'b0;
        w_res_class = '0;
        w_res_err   = 1'b0;
        w_res_depth = w_depth_inc;
        case (r_state)
            S_IDLE: begin
                w_in_ready  = 1'b1;
                w_cfg_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next = S_WALK;
                end
            end
            S_WALK: begin
                if (r_fetched) begin
                    if (r_bad) begin
                        w_finish  = 1'b1;
                        w_res_err = 1'b1;
                    end else if (w_leaf) begin
                        w_finish    = 1'b1;
                        w_res_class = w_thresh[CLASS_W-1:0];
                    end else if (w_depth_inc == DEP_W'(MAX_DEPTH)) begin
                        w_finish  = 1'b1;
                        w_res_err = 1'b1;
                    end
                    if (w_finish) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetched   <= 1'b0;
            r_bad       <= 1'b0;
            r_depth     <= '0;
            r_out_class <= '0;
            r_out_depth <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_fetched <= 1'b0;
                        r_bad     <= 1'b0;
                        r_depth   <= '0;
                    end
                end
                S_WALK: begin
                    if (!r_fetched) begin
                        r_fetched <= 1'b1;
                    end else if (w_finish) begin
                        r_out_class <= w_res_class;
                        r_out_depth <= w_res_depth;
                        r_out_err   <= w_res_err;
                    end else begin
                        r_depth <= w_depth_inc;
                        r_bad   <= w_child_bad;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table survives reset; a write at the accept edge is visible to the root fetch
    always_ff @(posedge clk) begin
        if (w_cfg_ready && bus.cfg_we && int'(bus.cfg_addr) < N_NODES) begin
            r_table[bus.cfg_addr] <= bus.cfg_wdata;
        end
        if (w_in_ready && bus.in_valid) begin
            r_feat <= bus.in_feat;
        end
        if (r_state == S_WALK) begin
            if (!r_fetched) begin
                r_node <= r_table[0];
            end else if (!w_finish && !w_child_bad) begin
                r_node <= r_table[w_child];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.cfg_ready = w_cfg_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_class = r_out_class;
    assign bus.out_depth = r_out_depth;
    assign bus.out_err   = r_out_err;

`ifdef DTREE_CLASS_STATS_EN
    localparam int N_CLS = 2 ** CLASS_W;

    logic [15:0] r_stat [N_CLS];

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < N_CLS; i++) begin
                r_stat[i] <= '0;
            end
        end else if (w_out_valid && bus.out_ready && !r_out_err &&
                     r_stat[r_out_class] != 16'hFFFF) begin
            r_stat[r_out_class] <= r_stat[r_out_class] + 16'd1;
        end
    end

    for (genvar gs = 0; gs < N_CLS; gs++) begin : g_stat
        assign stat_cnt[gs*16 +: 16] = r_stat[gs];
    end
`else
    // Class statistics not built in this configuration.
`endif
endmodule
`default_nettype wire
